// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the five-channel select-tree scanner.
//   state_t   : scan controller states
//   CH_COUNT  : number of channels in the select tree
//   SEL_U..Y  : select codes driven onto s for each channel
//   ch2sel()  : channel index -> select code
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int CH_COUNT = 5;

    localparam logic [2:0] SEL_U = 3'b000;
    localparam logic [2:0] SEL_V = 3'b001;
    localparam logic [2:0] SEL_W = 3'b010;
    localparam logic [2:0] SEL_X = 3'b011;
    localparam logic [2:0] SEL_Y = 3'b100;

    // Unused indices fall back to channel u so 101..111 can never reach s.
    function automatic logic [2:0] ch2sel(input logic [2:0] idx);
        logic [2:0] sel;
        case (idx)
            3'd0:    sel = SEL_U;
            3'd1:    sel = SEL_V;
            3'd2:    sel = SEL_W;
            3'd3:    sel = SEL_X;
            3'd4:    sel = SEL_Y;
            default: sel = SEL_U;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mux_scan_capture_settle_cnt.sv
// Settle-time counter for one channel window.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   clr_i  : force the count back to zero on the next edge
//   hit_o  : count has reached SETTLE (sampling edge of the window)
module settle_cnt #(
    parameter logic [3:0] SETTLE = 4'd1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic hit_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = clr_i ? 4'd0 : cnt_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == SETTLE);

endmodule

// File: rtl/mux_scan_capture.sv
// Scans the five-input select tree one channel at a time, samples m after a
// settle window per channel and hands the assembled word downstream.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   start_i  : scan request (accepted in IDLE, or in HOLD on a transfer)
//   m_i      : select-tree output under scan
//   s_o      : registered select code
//   data_o   : captured word, bit4 = channel 0 ... bit0 = channel 4
//   valid_o  : data_o complete and stable
//   ready_i  : downstream accepts when valid_o & ready_i
//   busy_o   : high from scan start until the word is handed off
//
// state | meaning
// IDLE  | no scan in progress, s parked at channel u
// WAIT  | settling / sampling the current channel
// HOLD  | word presented, waiting for the downstream transfer
module mux_scan_capture
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       m_i,
    output logic [2:0] s_o,
    output logic [4:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       busy_o
);

    localparam logic [2:0] LAST_CH = 3'(CH_COUNT - 1);

    state_t     state_q, state_d;
    logic [2:0] ch_q, ch_d;
    logic [2:0] s_q, s_d;
    logic [4:0] shadow_q, shadow_d;
    logic [4:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       cnt_clr;
    logic       hit;

    // The counter only runs inside WAIT; it restarts for every new channel.
    assign cnt_clr = (state_q != WAIT) || hit;

    settle_cnt #(
        .SETTLE(4'(SETTLE))
    ) u_settle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .hit_o (hit)
    );

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        s_d      = s_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = valid_q;
        busy_d   = busy_q;

        case (state_q)
            IDLE: begin
                s_d    = SEL_U;
                busy_d = 1'b0;
                if (start_i) begin
                    ch_d    = 3'd0;
                    s_d     = ch2sel(3'd0);
                    busy_d  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (hit) begin
                    shadow_d[LAST_CH - ch_q] = m_i;
                    if (ch_q == LAST_CH) begin
                        // Last sample goes straight into the word; the shadow
                        // copy of bit0 would only be visible one cycle later.
                        data_d  = {shadow_q[4:1], m_i};
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else begin
                        ch_d = ch_q + 3'd1;
                        s_d  = ch2sel(ch_q + 3'd1);
                    end
                end
            end
            HOLD: begin
                if (valid_q && ready_i) begin
                    valid_d = 1'b0;
                    if (start_i) begin
                        ch_d    = 3'd0;
                        s_d     = ch2sel(3'd0);
                        state_d = WAIT;
                    end else begin
                        s_d     = SEL_U;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ch_q     <= 3'd0;
            s_q      <= SEL_U;
            shadow_q <= 5'd0;
            data_q   <= 5'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            s_q      <= s_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign s_o     = s_q;
    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_mux_scan_capture.sv
// Two scanners (SETTLE=1 and SETTLE=0) share one stimulus stream. A
// transaction-level model predicts, per instance, when a scan is accepted,
// when the word becomes valid and what the word is; a negedge monitor
// compares outputs against those predictions and a queue of expected words.
module tb_mux_scan_capture;

    logic       clk;
    logic       rst;
    logic       start_i;
    logic       ready_i;
    logic [4:0] chan;          // {u,v,w,x,y} applied to the select tree
    logic       m_i     [2];
    logic [2:0] s_o     [2];
    logic [4:0] data_o  [2];
    logic       valid_o [2];
    logic       busy_o  [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic mon_en = 1'b0;

    // reference model state, one entry per instance
    logic       m_busy     [2];
    int         m_acc      [2];
    int         m_valid_at [2];
    logic [4:0] m_last     [2];
    logic [4:0] q0[$];
    logic [4:0] q1[$];

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    // behavioural select tree: code n routes channel n, bit (4-n) of chan
    function automatic logic sel_tree(input logic [4:0] c, input logic [2:0] s);
        logic [2:0] idx;
        if (s > 3'd4) return 1'b0;
        idx = 3'd4 - s;
        return c[idx];
    endfunction

    assign m_i[0] = sel_tree(chan, s_o[0]);
    assign m_i[1] = sel_tree(chan, s_o[1]);

    mux_scan_capture #(.SETTLE(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .start_i(start_i), .m_i(m_i[0]), .s_o(s_o[0]),
        .data_o(data_o[0]), .valid_o(valid_o[0]), .ready_i(ready_i), .busy_o(busy_o[0])
    );

    mux_scan_capture #(.SETTLE(0)) u_dut_s0 (
        .clk(clk), .rst(rst), .start_i(start_i), .m_i(m_i[1]), .s_o(s_o[1]),
        .data_o(data_o[1]), .valid_o(valid_o[1]), .ready_i(ready_i), .busy_o(busy_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, i, cyc, act, exp);
        end
    endtask

    function automatic int q_size(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [4:0] q_front(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_push(input int i, input logic [4:0] w);
        if (i == 0) q0.push_back(w); else q1.push_back(w);
    endtask

    task automatic q_pop_front(input int i);
        if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endtask

    task automatic q_pop_back(input int i);
        if (i == 0) void'(q0.pop_back()); else void'(q1.pop_back());
    endtask

    task automatic accept(input int i);
        m_busy[i]     = 1'b1;
        m_acc[i]      = cyc;
        m_valid_at[i] = cyc + 5 * (settle_of(i) + 1);
        q_push(i, chan);
    endtask

    // apply inputs, take one edge, update the model for that edge
    task automatic step(input logic st, input logic rd, input logic rs);
        start_i = st;
        ready_i = rd;
        rst     = rs;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rs) begin
                if (m_busy[i]) q_pop_back(i);
                m_busy[i] = 1'b0;
                m_last[i] = 5'd0;
            end else if (!m_busy[i]) begin
                if (st) accept(i);
            end else if (cyc > m_valid_at[i] && rd) begin
                if (st) accept(i);
                else m_busy[i] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input logic rd);
        for (int k = 0; k < n; k++) step(1'b0, rd, 1'b0);
    endtask

    // true when neither instance will sample m on the coming edge
    function automatic logic chan_free();
        for (int i = 0; i < 2; i++)
            if (m_busy[i] && cyc < m_valid_at[i]) return 1'b0;
        return 1'b1;
    endfunction

    logic       mon_ev;
    int         mon_ch;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("busy", i, 32'(busy_o[i]), 32'(m_busy[i]));
                mon_ev = m_busy[i] && (cyc >= m_valid_at[i]);
                chk("valid", i, 32'(valid_o[i]), 32'(mon_ev));
                if (!m_busy[i]) begin
                    chk("s_idle", i, 32'(s_o[i]), 32'd0);
                end else if (!mon_ev) begin
                    mon_ch = (cyc - m_acc[i]) / (settle_of(i) + 1);
                    chk("s_scan", i, 32'(s_o[i]), 32'(mon_ch));
                end
                if (mon_ev) begin
                    chk("word_queued", i, 32'(q_size(i) > 0), 32'd1);
                    if (q_size(i) > 0) chk("data", i, 32'(data_o[i]), 32'(q_front(i)));
                end else begin
                    chk("data_hold", i, 32'(data_o[i]), 32'(m_last[i]));
                end
                if (valid_o[i] && ready_i) begin
                    chk("xfer_expected", i, 32'(q_size(i) > 0), 32'd1);
                    if (q_size(i) > 0) begin
                        m_last[i] = q_front(i);
                        q_pop_front(i);
                    end
                end
            end
        end
    end

    logic st_r, rd_r, rs_r;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0; m_acc[i] = 0; m_valid_at[i] = 0; m_last[i] = 5'd0;
        end
        start_i = 1'b0; ready_i = 1'b0; rst = 1'b1; chan = 5'b10110;

        step(1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);

        // basic scan, ready high
        chan = 5'b10110;
        step(1'b1, 1'b1, 1'b0);
        idle(14, 1'b1);

        // ready held low for a long time, then a single transfer
        step(1'b1, 1'b0, 1'b0);
        idle(30, 1'b0);
        idle(4, 1'b1);

        // start pulsed mid-scan (channel 2 of the SETTLE=1 instance) is ignored
        step(1'b1, 1'b1, 1'b0);
        idle(4, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        idle(12, 1'b1);

        // reset at channel 3, then a fresh full scan
        chan = 5'b01101;
        step(1'b1, 1'b0, 1'b0);
        idle(6, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(12, 1'b1);

        // back-to-back scans with a new input word on the restart edge
        chan = 5'b10110;
        step(1'b1, 1'b0, 1'b0);
        idle(10, 1'b0);
        chan = 5'b01001;
        step(1'b1, 1'b1, 1'b0);
        idle(12, 1'b1);

        // u changed after its sampling edge must not reach the word
        chan = 5'b11111;
        step(1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);
        chan[4] = 1'b0;
        idle(12, 1'b1);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if (chan_free()) chan = 5'($urandom);
            st_r = ($urandom_range(0, 3) == 0);
            rd_r = ($urandom_range(0, 2) != 0);
            rs_r = ($urandom_range(0, 80) == 0);
            if (rs_r) rd_r = 1'b0;
            step(st_r, rd_r, rs_r);
        end

        idle(40, 1'b1);
        chk("q_drained", 0, 32'(q0.size()), 32'd0);
        chk("q_drained", 1, 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
